// File: rtl/slot_reel_ctrl.sv
// Three-reel slot sequencer: gates reel step enables, stops one reel per press
// (or on timeout), judges the stopped digits and holds the result for display.
module slot_reel_ctrl #(
   parameter int TIMEOUT_TICKS = 40,
   parameter int RESULT_TICKS  = 3,
   parameter int TICK_W        = 8
) (
   input  logic       clk,
   input  logic       i_sclr,
   input  logic       i_btn,
   input  logic       i_tick,
   input  logic [3:0] i_reel0,
   input  logic [3:0] i_reel1,
   input  logic [3:0] i_reel2,
   output logic [2:0] o_reel_en,
   output logic       o_spinning,
   output logic       o_result_vld,
   output logic       o_jackpot,
   output logic       o_pair,
   output logic [7:0] o_wins
);

   typedef enum logic [2:0] {
      IDLE,
      SPIN3,
      SPIN2,
      SPIN1,
      JUDGE,
      RESULT
   } state_e;

   localparam logic [TICK_W-1:0] TO_LAST  = TICK_W'(TIMEOUT_TICKS - 1);
   localparam logic [TICK_W-1:0] RES_LAST = TICK_W'(RESULT_TICKS - 1);
   localparam logic [TICK_W-1:0] CNT_ONE  = TICK_W'(1);

   state_e            state_q, state_d;
   logic [2:0]        mask_q, mask_d;
   logic [TICK_W-1:0] cnt_q, cnt_d;
   logic              jackpot_q, jackpot_d;
   logic              pair_q, pair_d;
   logic [7:0]        wins_q, wins_d;

   logic              eq01, eq12, eq02, jp;

   assign eq01 = (i_reel0 == i_reel1);
   assign eq12 = (i_reel1 == i_reel2);
   assign eq02 = (i_reel0 == i_reel2);
   assign jp   = eq01 && eq12;

   always_ff @(posedge clk or posedge i_sclr) begin
      if (i_sclr) begin
         state_q   <= IDLE;
         mask_q    <= 3'b000;
         cnt_q     <= '0;
         jackpot_q <= 1'b0;
         pair_q    <= 1'b0;
         wins_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         cnt_q     <= cnt_d;
         jackpot_q <= jackpot_d;
         pair_q    <= pair_d;
         wins_q    <= wins_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      cnt_d     = cnt_q;
      jackpot_d = jackpot_q;
      pair_d    = pair_q;
      wins_d    = wins_q;
      case (state_q)
         IDLE: begin
            if (i_btn) begin
               state_d = SPIN3;
               mask_d  = 3'b111;
               cnt_d   = '0;
            end
         end
         SPIN3, SPIN2, SPIN1: begin
            // A press and a timeout in the same cycle collapse into one stop.
            if (i_btn || (i_tick && cnt_q == TO_LAST)) begin
               mask_d = mask_q & (mask_q - 3'd1);
               cnt_d  = '0;
               case (state_q)
                  SPIN3:   state_d = SPIN2;
                  SPIN2:   state_d = SPIN1;
                  default: state_d = JUDGE;
               endcase
            end else if (i_tick) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         JUDGE: begin
            jackpot_d = jp;
            pair_d    = !jp && (eq01 || eq12 || eq02);
            if (jp && wins_q != 8'hFF) wins_d = wins_q + 8'd1;
            state_d = RESULT;
            cnt_d   = '0;
         end
         RESULT: begin
            if (i_btn) begin
               state_d   = SPIN3;
               mask_d    = 3'b111;
               cnt_d     = '0;
               jackpot_d = 1'b0;
               pair_d    = 1'b0;
            end else if (i_tick) begin
               if (cnt_q == RES_LAST) begin
                  state_d   = IDLE;
                  cnt_d     = '0;
                  jackpot_d = 1'b0;
                  pair_d    = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            mask_d  = 3'b000;
            cnt_d   = '0;
         end
      endcase
   end

   assign o_reel_en    = {3{i_tick}} & mask_q;
   assign o_spinning   = |mask_q;
   assign o_result_vld = (state_q == RESULT);
   assign o_jackpot    = jackpot_q;
   assign o_pair       = pair_q;
   assign o_wins       = wins_q;

endmodule

// File: tb/tb_slot_reel_ctrl.sv
// Directed bench for slot_reel_ctrl with short timeout/result windows.
module tb_slot_reel_ctrl;

   logic       clk = 1'b0;
   logic       i_sclr, i_btn, i_tick;
   logic [3:0] i_reel0, i_reel1, i_reel2;
   logic [2:0] o_reel_en;
   logic       o_spinning, o_result_vld, o_jackpot, o_pair;
   logic [7:0] o_wins;

   int checks = 0;
   int failures = 0;
   int exp_wins = 0;

   slot_reel_ctrl #(.TIMEOUT_TICKS(4), .RESULT_TICKS(3), .TICK_W(8)) dut (
      .clk(clk), .i_sclr(i_sclr), .i_btn(i_btn), .i_tick(i_tick),
      .i_reel0(i_reel0), .i_reel1(i_reel1), .i_reel2(i_reel2),
      .o_reel_en(o_reel_en), .o_spinning(o_spinning),
      .o_result_vld(o_result_vld), .o_jackpot(o_jackpot), .o_pair(o_pair),
      .o_wins(o_wins)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change at negedge, are sampled at posedge, cleared 1 time unit later.
   task automatic step(input logic b, input logic t);
      @(negedge clk);
      i_btn = b; i_tick = t;
      @(posedge clk); #1;
      i_btn = 1'b0; i_tick = 1'b0;
   endtask

   task automatic chk_en(input string tag, input logic [2:0] exp);
      i_tick = 1'b1; #1;
      chk(tag, {29'd0, o_reel_en}, {29'd0, exp});
      i_tick = 1'b0; #1;
   endtask

   task automatic set_reels(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      i_reel0 = a; i_reel1 = b; i_reel2 = c;
   endtask

   // Start (from IDLE or RESULT), three stops, one JUDGE cycle -> in RESULT.
   task automatic play();
      repeat (4) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   initial begin
      i_sclr = 1'b1; i_btn = 1'b0; i_tick = 1'b0;
      set_reels(4'd0, 4'd0, 4'd0);
      repeat (2) @(posedge clk);
      #1;
      chk_en("rst_en", 3'b000);
      chk("rst_spin", {31'd0, o_spinning}, 32'd0);
      chk("rst_vld", {31'd0, o_result_vld}, 32'd0);
      chk("rst_jp", {31'd0, o_jackpot}, 32'd0);
      chk("rst_pair", {31'd0, o_pair}, 32'd0);
      chk("rst_wins", {24'd0, o_wins}, 32'd0);
      @(negedge clk); i_sclr = 1'b0;

      // idle ignores ticks
      step(1'b0, 1'b1);
      chk_en("idle_en", 3'b000);

      // async reset in SPIN2
      step(1'b1, 1'b0);
      chk_en("spin3_en", 3'b111);
      step(1'b1, 1'b0);
      chk_en("spin2_en", 3'b110);
      @(negedge clk); #2 i_sclr = 1'b1; #1;
      chk_en("rst_mid_en", 3'b000);
      chk("rst_mid_spin", {31'd0, o_spinning}, 32'd0);
      chk("rst_mid_wins", {24'd0, o_wins}, 32'd0);
      @(negedge clk); i_sclr = 1'b0;
      step(1'b0, 1'b1);
      chk_en("rst_idle_en", 3'b000);

      // jackpot 7/7/7 with press coincident with tick in SPIN3
      set_reels(4'd7, 4'd7, 4'd7);
      step(1'b1, 1'b0);
      @(negedge clk); i_btn = 1'b1; i_tick = 1'b1; #1;
      chk("coin_en_before", {29'd0, o_reel_en}, 32'd7);
      @(posedge clk); #1; i_btn = 1'b0; i_tick = 1'b0;
      chk_en("coin_en_after", 3'b110);
      step(1'b1, 1'b0);
      chk_en("spin1_en", 3'b100);
      step(1'b1, 1'b0);
      chk("judge_spin", {31'd0, o_spinning}, 32'd0);
      chk("judge_vld", {31'd0, o_result_vld}, 32'd0);
      step(1'b0, 1'b0);
      chk("jp_vld", {31'd0, o_result_vld}, 32'd1);
      chk("jp_jp", {31'd0, o_jackpot}, 32'd1);
      chk("jp_pair", {31'd0, o_pair}, 32'd0);
      chk("jp_wins", {24'd0, o_wins}, 32'd1);
      exp_wins = 1;
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("res_hold_vld", {31'd0, o_result_vld}, 32'd1);
      chk("res_hold_jp", {31'd0, o_jackpot}, 32'd1);
      step(1'b0, 1'b1);
      chk("res_exit_vld", {31'd0, o_result_vld}, 32'd0);
      chk("res_exit_jp", {31'd0, o_jackpot}, 32'd0);

      // pair 3/5/3, press during JUDGE ignored
      set_reels(4'd3, 4'd5, 4'd3);
      repeat (4) step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("pair_vld", {31'd0, o_result_vld}, 32'd1);
      chk("pair_pair", {31'd0, o_pair}, 32'd1);
      chk("pair_jp", {31'd0, o_jackpot}, 32'd0);
      chk("pair_wins", {24'd0, o_wins}, 32'd1);

      // press in RESULT restarts immediately
      step(1'b1, 1'b0);
      chk("restart_vld", {31'd0, o_result_vld}, 32'd0);
      chk("restart_pair", {31'd0, o_pair}, 32'd0);
      chk_en("restart_en", 3'b111);

      // no match 1/2/3
      set_reels(4'd1, 4'd2, 4'd3);
      repeat (3) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk("none_vld", {31'd0, o_result_vld}, 32'd1);
      chk("none_jp", {31'd0, o_jackpot}, 32'd0);
      chk("none_pair", {31'd0, o_pair}, 32'd0);
      chk("none_wins", {24'd0, o_wins}, 32'd1);

      // timeout: one reel every 4 ticks, raw >9 digits compare as bits
      set_reels(4'd12, 4'd12, 4'd9);
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b1);
      chk_en("to_3_en", 3'b111);
      step(1'b0, 1'b1);
      chk_en("to_4_en", 3'b110);
      repeat (3) step(1'b0, 1'b1);
      chk_en("to_7_en", 3'b110);
      step(1'b0, 1'b1);
      chk_en("to_8_en", 3'b100);
      repeat (4) step(1'b0, 1'b1);
      chk("to_12_spin", {31'd0, o_spinning}, 32'd0);
      chk("to_12_vld", {31'd0, o_result_vld}, 32'd0);
      step(1'b0, 1'b0);
      chk("to_res_vld", {31'd0, o_result_vld}, 32'd1);
      chk("to_res_pair", {31'd0, o_pair}, 32'd1);

      // press together with timeout tick -> one stop only
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      chk_en("both_en", 3'b110);
      repeat (3) step(1'b0, 1'b1);
      chk_en("both_cnt_en", 3'b110);
      step(1'b0, 1'b1);
      chk_en("both_next_en", 3'b100);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk("both_vld", {31'd0, o_result_vld}, 32'd1);

      // saturation of the jackpot counter
      set_reels(4'd7, 4'd7, 4'd7);
      for (int g = 0; g < 258; g++) begin
         play();
         if (exp_wins < 255) exp_wins++;
         chk("sat_wins", {24'd0, o_wins}, exp_wins);
      end
      chk("sat_final", {24'd0, o_wins}, 32'd255);
      chk("sat_jp", {31'd0, o_jackpot}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
